read_sample_src: RTL

Sample-side server for the tag READ response. It answers the `read_sample_ctl` / `read_sample_clk` / `read_sample_datain` strobes issued by the READ responder. Per frame it fetches one WIDTH-bit sample word from the ADC/MSP430 word port over a four-phase handshake, then presents it MSB-first, one bit per sample-clock edge. It runs on the tag system clock and treats the READ strobes as asynchronous inputs.

---
 rtl/read_sample_src_pkg.sv | 21 ++
 rtl/read_sample_src_sync_edge.sv | 29 ++
 rtl/read_sample_src.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/read_sample_src_pkg.sv
// Shared definitions for the tag READ sample path: payload width,
// sample-server state encoding and bit-counter sizing.
package read_pkg;

    localparam int unsigned READ_PAYLOAD_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RELEASE,
        ST_READY,
        ST_SHIFT,
        ST_DONE
    } read_state_e;

    // Counter must hold the value WIDTH itself, hence one bit beyond clog2.
    function automatic int unsigned BITCNT_W(input int unsigned width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/read_sample_src_sync_edge.sv
// Multi-flop synchronizer for one asynchronous strobe, followed by a
// rise/fall detector on the synchronized level.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strobe_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/read_sample_src.sv
// Sample-side server for the READ response: fetches one word per frame over
// a four-phase ADC handshake and shifts it out MSB-first on sample-clock edges.
module read_sample_src
    import read_pkg::*;
#(
    parameter int unsigned WIDTH       = READ_PAYLOAD_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             read_sample_ctl,
    input  logic             read_sample_clk,
    output logic             read_sample_datain,
    output logic             adc_req,
    input  logic             adc_ack,
    input  logic [WIDTH-1:0] adc_data,
    output logic             underrun,
    output logic             frame_done
);

    localparam int unsigned    BW   = BITCNT_W(WIDTH);
    localparam logic [BW-1:0]  LAST = BW'(WIDTH);

    logic ctl_rise, ctl_fall, bclk_rise, bclk_fall_unused;

    sync_edge #(.STAGES(SYNC_STAGES)) u_ctl_sync (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .strobe_i (read_sample_ctl),
        .rise_o   (ctl_rise),
        .fall_o   (ctl_fall)
    );

    sync_edge #(.STAGES(SYNC_STAGES)) u_bclk_sync (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .strobe_i (read_sample_clk),
        .rise_o   (bclk_rise),
        .fall_o   (bclk_fall_unused)
    );

    read_state_e      state_q, state_d;
    logic [BW-1:0]    bitcnt_q, bitcnt_d, bitcnt_inc;
    logic [WIDTH-1:0] shreg_q, shreg_d, shifted;
    logic             dout_q, dout_d;
    logic             underrun_q, underrun_d;
    logic             done_q, done_d;
    logic             pend_q, pend_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            dout_q     <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            dout_q     <= dout_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
            pend_q     <= pend_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        dout_d     = dout_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;
        pend_d     = pend_q;
        adc_req    = 1'b0;
        bitcnt_inc = (bitcnt_q == LAST) ? LAST : bitcnt_q + 1'b1;
        shifted    = {shreg_q[WIDTH-2:0], 1'b0};

        if (ctl_fall) begin
            state_d = ST_IDLE;
            dout_d  = 1'b0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A rise seen while the previous ack is still high is
                    // remembered and honoured once the ack has drained.
                    if (ctl_rise || pend_q) begin
                        if (adc_ack) begin
                            pend_d = 1'b1;
                        end else begin
                            pend_d     = 1'b0;
                            state_d    = ST_REQ;
                            underrun_d = bclk_rise;
                            bitcnt_d   = bclk_rise ? BW'(1) : '0;
                        end
                    end
                end
                ST_REQ: begin
                    adc_req = 1'b1;
                    if (bclk_rise) begin
                        underrun_d = 1'b1;
                        bitcnt_d   = bitcnt_inc;
                    end
                    if (adc_ack) begin
                        shreg_d = adc_data;
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (bclk_rise) begin
                        underrun_d = 1'b1;
                        bitcnt_d   = bitcnt_inc;
                    end
                    if (!adc_ack) begin
                        state_d = ST_READY;
                    end
                end
                ST_READY: begin
                    // Edges already consumed during an underrun keep their
                    // count so the frame still ends on the WIDTH+1th edge.
                    if (bclk_rise) begin
                        if (bitcnt_q == LAST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            dout_d  = 1'b0;
                        end else begin
                            dout_d   = !underrun_q && shreg_q[WIDTH-1];
                            bitcnt_d = bitcnt_inc;
                            state_d  = ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (bclk_rise) begin
                        if (bitcnt_q < LAST) begin
                            shreg_d  = shifted;
                            dout_d   = !underrun_q && shifted[WIDTH-1];
                            bitcnt_d = bitcnt_inc;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            dout_d  = 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign read_sample_datain = dout_q;
    assign underrun           = underrun_q;
    assign frame_done         = done_q;

endmodule
